// File: rtl/axi_mem_pkg.sv
// -----------------------------------------------------------------------------
// axi_mem_pkg
// Shared types and constants for the AXI-to-memory bridge controllers.
//   burst_e      : AXI burst encoding (FIXED / INCR / WRAP)
//   RESP_*       : AXI B/R response codes used by the bridge
//   state_e      : write-controller FSM states
//   wrap_len_ok  : true for the burst lengths a WRAP burst may legally use
// -----------------------------------------------------------------------------
package axi_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DRAIN,
        ST_RESP
    } state_e;

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_mem_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_mem_addr_gen
// Combinational next-beat address calculator for AXI bursts. Kept free of
// state so a read controller can reuse it.
// Ports:
//   addr      in   current beat byte address
//   len       in   burst length minus one
//   size      in   log2 bytes per beat
//   burst     in   burst type (FIXED / INCR / WRAP)
//   next_addr out  byte address of the following beat
// WRAP with an unsupported length behaves as INCR; reserved burst type 2'b11
// also behaves as INCR.
// -----------------------------------------------------------------------------
module axi_mem_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] wrap_addr;

    always_comb begin
        bytes     = ADDR_ONE << size;
        // Align down to the beat size first, so an unaligned start address
        // lands on the next aligned beat.
        incr_addr = (addr & ~(bytes - ADDR_ONE)) + bytes;
        // Wrap window is (len+1)*bytes, always a power of two for legal lens:
        // only the bits inside the window advance, the rest are held.
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_ONE) << size) - ADDR_ONE;
        wrap_addr = (addr & ~wrap_mask) | ((addr + bytes) & wrap_mask);

        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = wrap_len_ok(len) ? wrap_addr : incr_addr;
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_mem_write_ctrl.sv
// -----------------------------------------------------------------------------
// axi_mem_write_ctrl
// Turns one AXI write burst (AW + buffered W stream) into single-beat memory
// write requests and returns one B response per burst. One burst in flight.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   aw_*                         AXI write-address channel (aw_ready_o out)
//   w_*                          AXI write-data channel (w_ready_o out);
//                                w_user_i is not used
//   b_*                          AXI write-response channel (b_ready_i in)
//   mem_req_o/we/addr/wdata/be   memory write request, mem_gnt_i accepts it
//
// Build option: define AXI_MEM_WR_CHECK_EN to enable protocol checking
// (early/late w_last_i -> SLVERR with draining of surplus beats, oversized
// aw_size_i -> SLVERR with no memory writes). Without it, w_last_i is ignored,
// bursts end on the beat count, oversized sizes are clamped and every response
// is OKAY.
// -----------------------------------------------------------------------------
module axi_mem_write_ctrl
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 10,
    parameter int USER_WIDTH = 6,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  aw_valid_i,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]            aw_len_i,
    input  logic [2:0]            aw_size_i,
    input  logic [1:0]            aw_burst_i,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [USER_WIDTH-1:0] aw_user_i,
    output logic                  aw_ready_o,

    input  logic                  w_valid_i,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    input  logic [STRB_WIDTH-1:0] w_strb_i,
    input  logic [USER_WIDTH-1:0] w_user_i,
    input  logic                  w_last_i,
    output logic                  w_ready_o,

    output logic                  b_valid_o,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]            b_resp_o,
    output logic [USER_WIDTH-1:0] b_user_o,
    input  logic                  b_ready_i,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [STRB_WIDTH-1:0] mem_be_o,
    input  logic                  mem_gnt_i
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));

    state_e                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg,  addr_next;
    logic [7:0]            len_reg,   len_next;
    logic [2:0]            size_reg,  size_next;
    logic [1:0]            burst_reg, burst_next;
    logic [ID_WIDTH-1:0]   id_reg,    id_next;
    logic [USER_WIDTH-1:0] user_reg,  user_next;
    logic [7:0]            count_reg, count_next;
    logic                  err_reg,   err_next;

    logic [ADDR_WIDTH-1:0] gen_next_addr;
    logic                  beat_done;

    logic unused_inputs;
    assign unused_inputs = ^{w_user_i, w_last_i};

    axi_mem_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr      (addr_reg),
        .len       (len_reg),
        .size      (size_reg),
        .burst     (burst_reg),
        .next_addr (gen_next_addr)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            len_reg   <= '0;
            size_reg  <= '0;
            burst_reg <= '0;
            id_reg    <= '0;
            user_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            len_reg   <= len_next;
            size_reg  <= size_next;
            burst_reg <= burst_next;
            id_reg    <= id_next;
            user_reg  <= user_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        len_next   = len_reg;
        size_next  = size_reg;
        burst_next = burst_reg;
        id_next    = id_reg;
        user_next  = user_reg;
        count_next = count_reg;
        err_next   = err_reg;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        mem_req_o  = 1'b0;
        b_valid_o  = 1'b0;
        beat_done  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                aw_ready_o = 1'b1;
                if (aw_valid_i) begin
                    addr_next  = aw_addr_i;
                    len_next   = aw_len_i;
                    burst_next = aw_burst_i;
                    id_next    = aw_id_i;
                    user_next  = aw_user_i;
                    count_next = '0;
`ifdef AXI_MEM_WR_CHECK_EN
                    size_next  = aw_size_i;
                    err_next   = (aw_size_i > MAX_SIZE);
`else
                    size_next  = (aw_size_i > MAX_SIZE) ? MAX_SIZE : aw_size_i;
                    err_next   = 1'b0;
`endif
                    state_next = ST_BURST;
                end
            end

            ST_BURST: begin
                // While in BURST the error flag can only have come from an
                // oversized beat at AW capture: beats are then swallowed
                // without touching memory, so no grant is needed.
                mem_req_o = w_valid_i & ~err_reg;
                beat_done = w_valid_i & (mem_gnt_i | err_reg);
                w_ready_o = beat_done;
                if (beat_done) begin
                    count_next = count_reg + 8'd1;
                    addr_next  = gen_next_addr;
`ifdef AXI_MEM_WR_CHECK_EN
                    if (w_last_i) begin
                        if (count_reg != len_reg) begin
                            err_next = 1'b1;
                        end
                        state_next = ST_RESP;
                    end else if (count_reg == len_reg) begin
                        err_next   = 1'b1;
                        state_next = ST_DRAIN;
                    end
`else
                    if (count_reg == len_reg) begin
                        state_next = ST_RESP;
                    end
`endif
                end
            end

`ifdef AXI_MEM_WR_CHECK_EN
            ST_DRAIN: begin
                // Surplus beats after a missing w_last are discarded.
                w_ready_o = 1'b1;
                if (w_valid_i && w_last_i) begin
                    state_next = ST_RESP;
                end
            end
`endif

            ST_RESP: begin
                b_valid_o = 1'b1;
                if (b_ready_i) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_we_o    = mem_req_o;
    assign mem_addr_o  = addr_reg;
    assign mem_wdata_o = w_data_i;
    assign mem_be_o    = w_strb_i;
    assign b_id_o      = id_reg;
    assign b_user_o    = user_reg;
`ifdef AXI_MEM_WR_CHECK_EN
    assign b_resp_o    = err_reg ? RESP_SLVERR : RESP_OKAY;
`else
    assign b_resp_o    = RESP_OKAY;
`endif

endmodule

// File: tb/tb_axi_mem_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_write_ctrl
// Self-checking bench for axi_mem_write_ctrl (default parameters). Expected
// memory writes and B responses come from a burst-level model: beat addresses
// are computed directly from the start address and beat index, and the
// number of writes / response code from where w_last sits relative to len.
// Works with and without AXI_MEM_WR_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_axi_mem_write_ctrl;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 10;
    localparam int UW = 6;
    localparam int SW = DW / 8;
    localparam int MAXSZ = 3;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          aw_valid_i;
    logic [AW-1:0] aw_addr_i;
    logic [7:0]    aw_len_i;
    logic [2:0]    aw_size_i;
    logic [1:0]    aw_burst_i;
    logic [IW-1:0] aw_id_i;
    logic [UW-1:0] aw_user_i;
    logic          aw_ready_o;
    logic          w_valid_i;
    logic [DW-1:0] w_data_i;
    logic [SW-1:0] w_strb_i;
    logic [UW-1:0] w_user_i;
    logic          w_last_i;
    logic          w_ready_o;
    logic          b_valid_o;
    logic [IW-1:0] b_id_o;
    logic [1:0]    b_resp_o;
    logic [UW-1:0] b_user_o;
    logic          b_ready_i;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [SW-1:0] mem_be_o;
    logic          mem_gnt_i;

    int n_cmp = 0;
    int n_mis = 0;
    int n_burst = 0;

    always #5 clk = ~clk;

    axi_mem_write_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .USER_WIDTH (UW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .aw_valid_i  (aw_valid_i),
        .aw_addr_i   (aw_addr_i),
        .aw_len_i    (aw_len_i),
        .aw_size_i   (aw_size_i),
        .aw_burst_i  (aw_burst_i),
        .aw_id_i     (aw_id_i),
        .aw_user_i   (aw_user_i),
        .aw_ready_o  (aw_ready_o),
        .w_valid_i   (w_valid_i),
        .w_data_i    (w_data_i),
        .w_strb_i    (w_strb_i),
        .w_user_i    (w_user_i),
        .w_last_i    (w_last_i),
        .w_ready_o   (w_ready_o),
        .b_valid_o   (b_valid_o),
        .b_id_o      (b_id_o),
        .b_resp_o    (b_resp_o),
        .b_user_o    (b_user_o),
        .b_ready_i   (b_ready_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_gnt_i   (mem_gnt_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Address of beat i, straight from the burst rules.
    function automatic logic [31:0] exp_addr(input logic [31:0] start, input int len,
                                             input int size, input int burst, input int i);
        longint s, bytes, wl, off;
        s     = longint'(start);
        bytes = longint'(1) << size;
        if (burst == 0) return start;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            wl  = longint'(len + 1) * bytes;
            off = s % wl;
            return 32'(s - off + (off + longint'(i) * bytes) % wl);
        end
        if (i == 0) return start;
        return 32'(s - (s % bytes) + longint'(i) * bytes);
    endfunction

    task automatic idle_inputs();
        aw_valid_i = 1'b0;
        aw_addr_i  = '0;
        aw_len_i   = '0;
        aw_size_i  = '0;
        aw_burst_i = '0;
        aw_id_i    = '0;
        aw_user_i  = '0;
        w_valid_i  = 1'b0;
        w_data_i   = '0;
        w_strb_i   = '0;
        w_user_i   = '0;
        w_last_i   = 1'b0;
        b_ready_i  = 1'b0;
        mem_gnt_i  = 1'b0;
    endtask

    // Runs one burst. Entered and left at a negedge with the DUT idle.
    // lastpos: beat index carrying w_last; gmode: 0 grant always, 1 toggle,
    // 2 random; bhold: keep b_ready low for the first 3 response cycles.
    task automatic run_burst(input logic [31:0] addr, input int len, input int size,
                             input int burst, input int lastpos, input int gmode,
                             input bit bhold);
        logic [DW-1:0] wd[$];
        logic [SW-1:0] ws[$];
        logic          wl[$];
        logic [IW-1:0] id;
        logic [UW-1:0] user;
        logic [1:0]    exp_resp;
        int  eff_size, nbeats, nwr, wi, wri, cyc, bwait;
        bit  done, bpend;

        id   = IW'($urandom);
        user = UW'($urandom);
`ifdef AXI_MEM_WR_CHECK_EN
        eff_size = size;
        nbeats   = lastpos + 1;
        if (size > MAXSZ)       nwr = 0;
        else if (lastpos < len) nwr = lastpos + 1;
        else                    nwr = len + 1;
        exp_resp = (size > MAXSZ || lastpos != len) ? 2'b10 : 2'b00;
`else
        eff_size = (size > MAXSZ) ? MAXSZ : size;
        nbeats   = len + 1;
        nwr      = len + 1;
        exp_resp = 2'b00;
`endif
        for (int i = 0; i < nbeats; i++) begin
            wd.push_back({$urandom, $urandom});
            ws.push_back(SW'($urandom));
            wl.push_back(i == lastpos);
        end

        // AW cycle: W junk is offered too and must be refused.
        aw_valid_i = 1'b1;
        aw_addr_i  = addr;
        aw_len_i   = 8'(len);
        aw_size_i  = 3'(size);
        aw_burst_i = 2'(burst);
        aw_id_i    = id;
        aw_user_i  = user;
        w_valid_i  = 1'b1;
        w_data_i   = {$urandom, $urandom};
        w_last_i   = 1'b1;
        mem_gnt_i  = 1'b1;
        b_ready_i  = 1'b0;
        #1;
        chk("aw_ready", aw_ready_o, 1'b1);
        chk("aw_no_mem", mem_req_o, 1'b0);
        chk("aw_no_wready", w_ready_o, 1'b0);
        @(negedge clk);
        aw_valid_i = 1'b0;

        wi = 0; wri = 0; cyc = 0; bwait = 0; done = 0; bpend = 0;
        while (!done && cyc < 2000) begin
            if (wi < nbeats) begin
                w_valid_i = ($urandom_range(0, 3) != 0);
                w_data_i  = wd[wi];
                w_strb_i  = ws[wi];
                w_last_i  = wl[wi];
            end else begin
                w_valid_i = 1'($urandom);
                w_data_i  = {$urandom, $urandom};
                w_strb_i  = SW'($urandom);
                w_last_i  = 1'($urandom);
            end
            mem_gnt_i = (gmode == 0) ? 1'b1 : (gmode == 1) ? 1'(cyc % 2) : 1'($urandom);
            b_ready_i = bhold ? (bwait >= 3) : 1'($urandom);
            #1;
            if (mem_req_o) chk("mem_we", mem_we_o, 1'b1);
            if (mem_req_o && mem_gnt_i) begin
                chk("gnt_consume", w_ready_o && w_valid_i, 1'b1);
                chk("extra_write", wri < nwr, 1'b1);
                if (wri < nwr) begin
                    chk("mem_addr", mem_addr_o, exp_addr(addr, len, eff_size, burst, wri));
                    chk("mem_wdata", mem_wdata_o, wd[wri]);
                    chk("mem_be", mem_be_o, ws[wri]);
                    wri++;
                end
            end
            if (w_ready_o && w_valid_i) begin
                chk("w_accept_unexp", wi < nbeats, 1'b1);
                if (wi < nbeats) begin
                    chk("beat_write", mem_req_o && mem_gnt_i, wi < nwr);
                end
                wi++;
            end
            if (bpend) chk("b_hold", b_valid_o, 1'b1);
            bpend = 0;
            if (b_valid_o) begin
                chk("b_id", b_id_o, id);
                chk("b_user", b_user_o, user);
                chk("b_resp", b_resp_o, exp_resp);
                if (b_ready_i) begin
                    chk("b_beats", wi, nbeats);
                    chk("b_writes", wri, nwr);
                    done = 1;
                end else begin
                    bpend = 1;
                end
                bwait++;
            end
            cyc++;
            @(negedge clk);
        end
        w_valid_i = 1'b0;
        b_ready_i = 1'b0;
        n_burst++;
        $display("burst %0d: addr=%h len=%0d size=%0d type=%0d last@%0d -> writes %0d/%0d beats %0d/%0d resp exp %0d cycles %0d",
                 n_burst, addr, len, size, burst, lastpos, wri, nwr, wi, nbeats, exp_resp, cyc);
        if (!done) begin
            chk("timeout", done, 1'b1);
            rst_i = 1'b1;
            @(negedge clk);
            rst_i = 1'b0;
        end
    endtask

    initial begin
        int len, lp;
        idle_inputs();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("rst_aw_ready", aw_ready_o, 1'b1);
        chk("rst_b_valid", b_valid_o, 1'b0);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_w_ready", w_ready_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, '0);
        chk("rst_b_id", b_id_o, '0);
        chk("rst_b_resp", b_resp_o, '0);
        @(negedge clk);

        // Directed bursts.
        run_burst(32'h0000_0100, 3, 3, 1, 3, 0, 0);   // INCR
        run_burst(32'h0000_0038, 3, 3, 2, 3, 0, 0);   // WRAP
        run_burst(32'h0000_1000, 5, 3, 1, 5, 1, 1);   // backpressure
        run_burst(32'h0000_0200, 3, 3, 1, 1, 0, 0);   // early last
        run_burst(32'h0000_0300, 1, 3, 1, 3, 0, 0);   // late last
        run_burst(32'h0000_0400, 2, 4, 1, 2, 0, 0);   // oversized beat
        run_burst(32'h0000_0044, 2, 2, 0, 2, 2, 0);   // FIXED
        run_burst(32'h0000_0038, 2, 3, 2, 2, 0, 0);   // WRAP with len 2 -> INCR
        run_burst(32'hFFFF_FFF8, 1, 3, 1, 1, 0, 0);   // INCR address rollover
        run_burst(32'h0000_0103, 2, 2, 1, 2, 2, 1);   // unaligned INCR

        // Reset during beat 2 of an 8-beat burst.
        aw_valid_i = 1'b1;
        aw_addr_i  = 32'h0000_0500;
        aw_len_i   = 8'd7;
        aw_size_i  = 3'd3;
        aw_burst_i = 2'd1;
        aw_id_i    = 10'h155;
        mem_gnt_i  = 1'b1;
        @(negedge clk);
        aw_valid_i = 1'b0;
        w_valid_i  = 1'b1;
        w_last_i   = 1'b0;
        w_data_i   = 64'h1111;
        #1;
        chk("rst_mid_beat1_addr", mem_addr_o, 32'h0000_0500);
        @(negedge clk);
        w_data_i = 64'h2222;
        #1;
        chk("rst_mid_beat2_addr", mem_addr_o, 32'h0000_0508);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i     = 1'b0;
        w_valid_i = 1'b0;
        #1;
        chk("rst_mid_aw_ready", aw_ready_o, 1'b1);
        chk("rst_mid_b_valid", b_valid_o, 1'b0);
        chk("rst_mid_mem_req", mem_req_o, 1'b0);
        $display("burst reset: len=7 abandoned at beat 2");
        @(negedge clk);
        run_burst(32'h0000_0600, 7, 3, 1, 7, 2, 0);

        // Randomized bursts.
        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(0, 15);
            lp  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len + 3) : len;
            run_burst($urandom, len, $urandom_range(0, 4), $urandom_range(0, 2),
                      lp, $urandom_range(0, 2), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
